fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter PTR_WIDTH, default 4, pointer width: address bits plus one wrap bit.
REQ-002 Parameter ADDR_WIDTH, default 3, memory address width; SHALL equal PTR_WIDTH-1 (depth 8).
REQ-003 Parameter AF_THRESH, default 6, fill level at or above which almost_full asserts.
REQ-004 clk  input  1  write-domain clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 winc  input  1  write request for the current cycle.
REQ-007 wq2_rptr  input  PTR_WIDTH  Gray read pointer, already two-flop synchronized into clk domain.
REQ-008 wclken  output  1  memory write enable, = winc & ~wfull (combinational).
REQ-009 waddr  output  ADDR_WIDTH  memory write address = binary write pointer low bits.
REQ-010 wptr  output  PTR_WIDTH  registered Gray write pointer, sent to read domain.
REQ-011 wfull  output  1  registered FIFO-full flag.
REQ-012 almost_full  output  1  registered, level >= AF_THRESH.
REQ-013 wlevel  output  PTR_WIDTH  registered fill level, 0..2^ADDR_WIDTH.
REQ-014 overflow  output  1  sticky flag: write attempted while full.

Function
REQ-015 Binary pointer wbin SHALL increment by 1 (mod 2^PTR_WIDTH) on each edge where winc=1 and wfull=0; otherwise hold.
REQ-016 wbin_next = wbin + (winc & ~wfull); wgray_next = wbin_next ^ (wbin_next >> 1); wptr <= wgray_next every edge.
REQ-017 wptr SHALL change by exactly one bit per accepted write; never multiple bits in one edge.
REQ-018 wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}) every edge.
REQ-019 Write while wfull=1: wclken=0, pointer holds, data dropped, overflow <= 1 and stays 1 until reset.
REQ-020 wlevel <= wbin_next - gray2bin(wq2_rptr), modulo 2^PTR_WIDTH; almost_full <= (that value >= AF_THRESH).
REQ-021 Same-edge winc and read-pointer advance while full: write rejected (wfull still 1 at that edge); wfull deasserts the following edge.
REQ-022 Wrap-around: after 2^PTR_WIDTH accepted writes wptr returns to 0000, waddr wraps 7 -> 0; full/level unaffected by wrap.
REQ-023 Latency: wptr, wfull, wlevel, almost_full reflect an accepted write one edge later; a read-pointer change reflects one edge after wq2_rptr changes.
REQ-024 wfull and wptr SHALL be glitch-free flop outputs; no combinational path from wq2_rptr to wptr.

Reset
REQ-025 rst low SHALL asynchronously force wbin=0, wptr=0, wfull=0, almost_full=0, wlevel=0, overflow=0.
REQ-026 Reset assertion mid-write SHALL abort the write; first edge after release sees wclken = winc.
REQ-027 After release, with wq2_rptr=0, FIFO SHALL report empty-equivalent level 0 and accept writes immediately.

Structure
REQ-028 Shared package holds FIFO_PTR_WIDTH=4, FIFO_ADDR_WIDTH=3 and the gray2bin/bin2gray function definitions used by both FIFO ends.
REQ-029 One sub-module fifo_gray2bin (parameterized PTR_WIDTH, combinational XOR prefix) converts wq2_rptr for level computation.
REQ-030 Full compare and pointer arithmetic SHALL stay in fifo_wr_ctrl; no memory array in this block.

Verification
REQ-031 Reset, wq2_rptr=0, 8 consecutive winc -> wptr 0001,0011,0010,0110,0111,0101,0100,1100; wfull=1 after 8th edge; wlevel=8.
REQ-032 Full, winc=1 one cycle -> wclken=0, wptr stays 1100, overflow=1 and held until rst.
REQ-033 Full, wq2_rptr 0000->0001 -> wfull=0 next edge, wlevel=7, almost_full=1; next winc accepted, waddr=0.
REQ-034 Full, winc=1 on same edge wq2_rptr goes 0001 -> write rejected that edge, accepted next edge, wptr->1101.
REQ-035 Interleaved writes/reads for 20 writes -> wptr passes 1000->0000, waddr 7->0, wfull never spuriously set, level matches model.
REQ-036 rst pulsed low mid-burst at level 5 -> all outputs 0 immediately (asynchronous), no clock required.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkg.sv
// Definitions shared by both ends of the asynchronous FIFO:
// pointer geometry and the Gray/binary pointer conversions.
package fifo_wr_ctrl_pkg;

  localparam int FIFO_PTR_WIDTH  = 4;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_AF_THRESH  = 6;

  typedef logic [FIFO_PTR_WIDTH-1:0] fifo_ptr_t;

  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin);
    return bin ^ (bin >> 1'b1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray);
    fifo_ptr_t bin;
    bin[FIFO_PTR_WIDTH-1] = gray[FIFO_PTR_WIDTH-1];
    for (int i = FIFO_PTR_WIDTH-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: bit i is the XOR of Gray bits
// [PTR_WIDTH-1:i], built per bit so no bit depends on another output bit.
module fifo_gray2bin #(
  parameter int PTR_WIDTH = 4
) (
  input  logic [PTR_WIDTH-1:0] gray_i,
  output logic [PTR_WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[PTR_WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// registered full / almost-full / fill level, and a sticky overflow flag.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_AF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [PTR_WIDTH-1:0]  wq2_rptr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic                  wfull,
  output logic                  almost_full,
  output logic [PTR_WIDTH-1:0]  wlevel,
  output logic                  overflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(AF_THRESH);

  logic [PTR_WIDTH-1:0] wbin_q, wbin_d;
  logic [PTR_WIDTH-1:0] wgray_q, wgray_d;
  logic [PTR_WIDTH-1:0] wlevel_q, wlevel_d;
  logic                 wfull_q, wfull_d;
  logic                 afull_q, afull_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_WIDTH-1:0] rbin_s;
  logic [PTR_WIDTH-1:0] full_cmp_s;

  fifo_gray2bin #(
    .PTR_WIDTH(PTR_WIDTH)
  ) u_rptr_g2b (
    .gray_i(wq2_rptr),
    .bin_o (rbin_s)
  );

  assign wclken      = winc & ~wfull_q;
  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr        = wgray_q;
  assign wfull       = wfull_q;
  assign almost_full = afull_q;
  assign wlevel      = wlevel_q;
  assign overflow    = ovf_q;

  // Next pointer, full compare against the read pointer with its two top bits
  // inverted (same address, opposite lap), fill level and sticky overflow.
  always_comb begin
    wbin_d     = wbin_q;
    wgray_d    = wgray_q;
    wlevel_d   = wlevel_q;
    wfull_d    = wfull_q;
    afull_d    = afull_q;
    ovf_d      = ovf_q;
    full_cmp_s = {~wq2_rptr[PTR_WIDTH-1 -: 2], wq2_rptr[PTR_WIDTH-3:0]};

    if (wclken) begin
      wbin_d = wbin_q + PTR_ONE;
    end else begin
      wbin_d = wbin_q;
    end

    wgray_d  = wbin_d ^ (wbin_d >> 1'b1);
    wfull_d  = (wgray_d == full_cmp_s);
    wlevel_d = wbin_d - rbin_s;
    afull_d  = (wlevel_d >= AF_LEVEL);

    if (winc && wfull_q) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State register; every output flop clears asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: stimulus queues the expected outputs for
// each cycle, a negedge monitor pops and compares them against the DUT.
module tb_fifo_wr_ctrl;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst    = 1'b0;
  logic       winc   = 1'b0;
  logic [3:0] wq2_rptr = 4'b0000;
  logic       wclken;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  typedef struct {
    logic       wclken;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic [3:0] wlevel;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Hand-written 4-bit Gray sequence, index = binary count.
  logic [3:0] GRAY [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  // Reference model: counts of accepted writes and of reads visible in wq2_rptr.
  int   m_wr, m_rd, m_level;
  logic m_full, m_ovf;

  fifo_wr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .winc       (winc),
    .wq2_rptr   (wq2_rptr),
    .wclken     (wclken),
    .waddr      (waddr),
    .wptr       (wptr),
    .wfull      (wfull),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wclken",      {7'd0, wclken},      {7'd0, e.wclken});
      chk("waddr",       {5'd0, waddr},       {5'd0, e.waddr});
      chk("wptr",        {4'd0, wptr},        {4'd0, e.wptr});
      chk("wfull",       {7'd0, wfull},       {7'd0, e.wfull});
      chk("wlevel",      {4'd0, wlevel},      {4'd0, e.wlevel});
      chk("almost_full", {7'd0, almost_full}, {7'd0, e.af});
      chk("overflow",    {7'd0, overflow},    {7'd0, e.ovf});
    end
  end

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_level = 0; m_full = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic push_cur();
    exp_t e;
    e.wclken = winc & ~m_full;
    e.waddr  = 3'(m_wr % 8);
    e.wptr   = GRAY[m_wr % 16];
    e.wfull  = m_full;
    e.wlevel = 4'(m_level);
    e.af     = (m_level >= 6);
    e.ovf    = m_ovf;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs, queue what the DUT must show before the edge,
  // then advance the model across the edge.
  task automatic cyc(input logic w, input int rd);
    winc     = w;
    m_rd     = rd;
    wq2_rptr = GRAY[rd % 16];
    push_cur();
    if (w && m_full) m_ovf = 1'b1;
    if (w && !m_full) m_wr++;
    m_level = m_wr - m_rd;
    m_full  = (m_level == 8);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    cyc(1'b0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 0);
    cyc(1'b1, 0);
    cyc(1'b0, 0);
    // read advance on the same edge as a write into a full FIFO
    cyc(1'b1, 1);
    cyc(1'b1, 1);

    for (int i = 0; i < 100 && m_wr < 29; i++) begin
      int rd;
      rd = m_rd;
      if (m_rd < m_wr && (m_level >= 5 || i % 3 == 0)) rd = m_rd + 1;
      cyc(1'b1, rd);
    end

    for (int i = 0; i < 40 && m_level != 5; i++) begin
      if (m_level > 5) cyc(1'b0, m_rd + 1);
      else cyc(1'b1, m_rd);
    end

    // Level-5 snapshot mid-burst, then reset with the clock stopped.
    winc = 1'b1;
    push_cur();
    @(negedge clk); #1;
    clk_en = 1'b0;
    rst    = 1'b0;
    #2;
    chk("rst_wptr",        {4'd0, wptr},        8'd0);
    chk("rst_wfull",       {7'd0, wfull},       8'd0);
    chk("rst_almost_full", {7'd0, almost_full}, 8'd0);
    chk("rst_wlevel",      {4'd0, wlevel},      8'd0);
    chk("rst_overflow",    {7'd0, overflow},    8'd0);
    chk("rst_waddr",       {5'd0, waddr},       8'd0);
    chk("rst_wclken",      {7'd0, wclken},      8'd1);

    model_reset();
    wq2_rptr = 4'b0000;
    clk_en   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b1, 0);
    cyc(1'b1, 0);
    cyc(1'b0, 0);

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
